// File: rtl/axi_pkg.sv
// Shared AXI response/burst codes and FSM state encoding for the SRAM slave.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Encodings kept identical to the legacy constants so traces still line up.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_DATA = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    RD_ADDR = ST_RD_ADDR,
    RD_DATA = ST_RD_DATA,
    WR_DATA = ST_WR_DATA,
    WR_RESP = ST_WR_RESP
  } state_t;

endpackage

// File: rtl/axi_sram_burst_ctr.sv
// Beat counter and word-address generator shared by the read and write paths.
module axi_sram_burst_ctr
  import axi_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [3:0]        load_len,
  input  logic [1:0]        load_burst,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [4:0] remaining;
  logic [1:0] burst;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
      burst     <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= {1'b0, load_len} + 5'd1;
      burst     <= load_burst;
    end else if (advance) begin
      remaining <= remaining - 5'd1;
      // WRAP and the reserved code step like INCR; only FIXED holds.
      if (burst != BURST_FIXED) addr <= addr + ADDR_W'(1);
    end
  end

  assign last = (remaining == 5'd1);

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave serving one read or write burst at a time from a 1-cycle-latency SRAM.
// Optional AXI_SRAM_SLAVE_DELAY_EN inserts LFSR-driven 0-3 cycle delays before rvalid/bvalid.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_t            state, state_nxt;
  logic              prio_rd;
  logic [ID_W-1:0]   id_q;
  logic              err;
  logic              rd_first;
  logic [31:0]       rdata_q;
  logic              grant_rd, grant_wr;
  logic              rd_beat, wr_beat;
  logic              ctr_last;
  logic [ADDR_W-1:0] ctr_addr;
  logic              resp_go;

  assign grant_rd = (state == IDLE) && arvalid && (!awvalid || prio_rd);
  assign grant_wr = (state == IDLE) && awvalid && (!arvalid || !prio_rd);
  assign arready  = grant_rd;
  assign awready  = grant_wr;

  assign rd_beat = rvalid && rready;
  assign wr_beat = (state == WR_DATA) && wvalid;

  axi_sram_burst_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk        (clk),
    .reset      (reset),
    .load       (grant_rd || grant_wr),
    .load_addr  (grant_rd ? araddr[ADDR_W+1:2] : awaddr[ADDR_W+1:2]),
    .load_len   (grant_rd ? arlen[3:0] : awlen[3:0]),
    .load_burst (grant_rd ? arburst : awburst),
    .advance    ((rd_beat && !ctr_last) || wr_beat),
    .addr       (ctr_addr),
    .last       (ctr_last)
  );

`ifdef AXI_SRAM_SLAVE_DELAY_EN
  logic [7:0] lfsr;
  logic [1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr     <= 8'hA5;
      wait_cnt <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if ((state == RD_ADDR) || (wr_beat && ctr_last)) wait_cnt <= lfsr[1:0];
      else if (wait_cnt != 2'd0)                       wait_cnt <= wait_cnt - 2'd1;
    end
  end

  assign resp_go = (wait_cnt == 2'd0);
`else
  assign resp_go = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_rd) state_nxt = RD_ADDR;
               else if (grant_wr) state_nxt = WR_DATA;
      RD_ADDR: state_nxt = RD_DATA;
      RD_DATA: if (rd_beat) state_nxt = ctr_last ? IDLE : RD_ADDR;
      WR_DATA: if (wr_beat && ctr_last) state_nxt = WR_RESP;
      WR_RESP: if (bvalid && bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prio_rd  <= 1'b1;
      id_q     <= '0;
      err      <= 1'b0;
      rd_first <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state    <= state_nxt;
      rd_first <= (state == RD_ADDR);
      if (grant_rd) begin
        prio_rd <= 1'b0;
        id_q    <= arid;
      end else if (grant_wr) begin
        prio_rd <= 1'b1;
        id_q    <= awid;
      end
      if (rd_first) rdata_q <= ram_rdata;
      if (wr_beat && (wlast != ctr_last)) err <= 1'b1;
      else if (bvalid && bready)          err <= 1'b0;
    end
  end

  // SRAM data arrives in the first RD_DATA cycle; pass it through then and hold the copy after.
  assign rdata  = rd_first ? ram_rdata : rdata_q;
  assign rvalid = (state == RD_DATA) && resp_go;
  assign rid    = id_q;
  assign rresp  = RESP_OKAY;
  assign rlast  = (state == RD_DATA) && ctr_last;

  assign wready = (state == WR_DATA);
  assign bvalid = (state == WR_RESP) && resp_go;
  assign bid    = id_q;
  assign bresp  = ((state == WR_RESP) && err) ? RESP_SLVERR : RESP_OKAY;

  assign ram_en    = (state == RD_ADDR) || wr_beat;
  assign ram_wen   = wr_beat ? wstrb : 4'b0000;
  assign ram_addr  = ctr_addr;
  assign ram_wdata = wdata;

  logic unused_ok;
  assign unused_ok = ^{araddr[31:ADDR_W+2], araddr[1:0], arlen[7:4], arsize, arlock, arcache, arprot,
                       awaddr[31:ADDR_W+2], awaddr[1:0], awlen[7:4], awsize, awlock, awcache, awprot, wid};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: SRAM model plus a word-array reference memory.
module tb_axi_sram_slave;
  localparam int AW = 8;
  localparam int IW = 4;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [IW-1:0] arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata, ram_wdata, ram_rdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0] arcache, awcache, wstrb, ram_wen;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready, ram_en;
  logic [AW-1:0] ram_addr;

  axi_sram_slave #(.ADDR_W(AW), .ID_W(IW)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  logic [31:0] sram [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic pk_en;
  logic [AW-1:0] pk_addr;
  logic [31:0] pk_data;

  always @(posedge clk) begin
    if (pk_en) sram[pk_addr] <= pk_data;
    else if (ram_en) begin
      if (ram_wen == 4'b0000) ram_rdata <= sram[ram_addr];
      else for (int k = 0; k < 4; k++)
        if (ram_wen[k]) sram[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
    end
  end

  int passed = 0;
  int total = 0;

  function automatic int beat_word(input logic [31:0] addr, input logic [1:0] burst, input int i);
    int w;
    w = int'(addr >> 2) % DEPTH;
    if (burst == 2'b00) return w;
    return (w + i) % DEPTH;
  endfunction

  task automatic poke(input int a, input logic [31:0] d);
    pk_en = 1'b1; pk_addr = a[AW-1:0]; pk_data = d; ref_mem[a] = d;
    @(posedge clk); #1;
    pk_en = 1'b0;
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int stall_beat, input int stall_cyc);
    int nb, cyc;
    bit hs;
    logic [31:0] exp;
    nb = int'(len[3:0]) + 1;
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    total++;
    if (!hs) begin $display("FAIL ar_handshake: arready never seen, want 1"); return; end
    passed++;
    for (int b = 0; b < nb; b++) begin
      rready = (b == stall_beat && stall_cyc > 0) ? 1'b0 : 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!rvalid && cyc < 20) begin @(posedge clk); #1; cyc++; @(negedge clk); end
      total++;
      if (!rvalid) begin $display("FAIL rd_timeout beat %0d: rvalid=0, want 1", b); rready = 1'b0; return; end
      passed++;
`ifndef AXI_SRAM_SLAVE_DELAY_EN
      total++;
      if (cyc !== 1) $display("FAIL rd_latency beat %0d: %0d cycles after addr phase, want 1", b, cyc);
      else passed++;
`endif
      exp = ref_mem[beat_word(addr, burst, b)];
      total++;
      if ({rdata, rid, rlast, rresp} !== {exp, id, (b == nb - 1), 2'b00})
        $display("FAIL rd_beat %0d: data=%h id=%h last=%b resp=%b, want data=%h id=%h last=%b resp=00",
                 b, rdata, rid, rlast, rresp, exp, id, (b == nb - 1));
      else passed++;
      if (b == stall_beat && stall_cyc > 0) begin
        for (int s = 0; s < stall_cyc; s++) begin
          @(posedge clk); #1; @(negedge clk);
          total++;
          if ({rvalid, rdata, rid, rlast} !== {1'b1, exp, id, (b == nb - 1)})
            $display("FAIL rd_hold beat %0d: valid=%b data=%h id=%h last=%b, want 1 %h %h %b",
                     b, rvalid, rdata, rid, rlast, exp, id, (b == nb - 1));
          else passed++;
        end
        rready = 1'b1;
      end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    total++;
    if (rvalid !== 1'b0) $display("FAIL rd_extra: rvalid=%b after burst, want 0", rvalid);
    else passed++;
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input logic [31:0] base,
                          input bit rnd, input int early, input int bstall);
    int nb, w, bad;
    bit hs, exp_err;
    nb = int'(len[3:0]) + 1;
    exp_err = (early >= 0) && (early != nb - 1);
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk); hs = awready;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    total++;
    if (!hs) begin $display("FAIL aw_handshake: awready never seen, want 1"); return; end
    passed++;
    for (int i = 0; i < nb; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(posedge clk); #1; end
      wdata = rnd ? $urandom : base + 32'(i);
      wstrb = (strb == 4'b0000) ? 4'($urandom_range(0, 15)) : strb;
      wlast = (early >= 0) ? (i == early) : (i == nb - 1);
      wvalid = 1'b1;
      hs = 1'b0;
      for (int c = 0; c < 20 && !hs; c++) begin
        @(negedge clk); hs = wready;
        @(posedge clk); #1;
      end
      total++;
      if (!hs) begin
        $display("FAIL w_timeout beat %0d: wready never seen, want 1", i);
        wvalid = 1'b0; wlast = 1'b0; return;
      end
      passed++;
      w = beat_word(addr, burst, i);
      for (int k = 0; k < 4; k++) if (wstrb[k]) ref_mem[w][8*k +: 8] = wdata[8*k +: 8];
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = (bstall > 0) ? 1'b0 : 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk); hs = bvalid;
      if (!hs) begin @(posedge clk); #1; end
    end
    total++;
    if (!hs) begin $display("FAIL b_timeout: bvalid never seen, want 1"); bready = 1'b0; return; end
    passed++;
    total++;
    if ({bid, bresp} !== {id, exp_err ? 2'b10 : 2'b00})
      $display("FAIL b_resp: bid=%h bresp=%b, want bid=%h bresp=%b", bid, bresp, id, exp_err ? 2'b10 : 2'b00);
    else passed++;
    for (int s = 0; s < bstall; s++) begin
      @(posedge clk); #1; @(negedge clk);
      total++;
      if ({bvalid, bid} !== {1'b1, id}) $display("FAIL b_hold: bvalid=%b bid=%h, want 1 %h", bvalid, bid, id);
      else passed++;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    total++;
    if (bvalid !== 1'b0) $display("FAIL b_extra: bvalid=%b after response, want 0", bvalid);
    else passed++;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (sram[i] !== ref_mem[i]) bad++;
    total++;
    if (bad != 0) $display("FAIL mem_contents: %0d words differ, want 0", bad);
    else passed++;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({arready, awready, wready, rvalid, bvalid, rlast, ram_en, ram_wen, rresp, bresp, rid, bid, rdata} !== 55'd0)
      $display("FAIL reset_outputs: arr=%b awr=%b wr=%b rv=%b bv=%b rl=%b en=%b wen=%h rid=%h bid=%h rdata=%h, want all 0",
               arready, awready, wready, rvalid, bvalid, rlast, ram_en, ram_wen, rid, bid, rdata);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    arvalid = 1'b1;
    @(negedge clk);
    total++;
    if ({arready, awready, ram_en} !== 3'b100)
      $display("FAIL idle_arready: arready=%b awready=%b ram_en=%b, want 1 0 0", arready, awready, ram_en);
    else passed++;
    arvalid = 1'b0;
  endtask

  task automatic test_single_read;
    poke(32'h10, 32'hDEADBEEF);
    do_read(4'd3, 32'h40, 8'd0, 2'b01, -1, 0);
  endtask

  task automatic test_incr_write;
    do_write(4'd6, 32'h100, 8'd3, 2'b01, 4'hF, 32'd1, 1'b0, -1, 0);
    total++;
    if ({sram[8'h40], sram[8'h41], sram[8'h42], sram[8'h43]} !== {32'd1, 32'd2, 32'd3, 32'd4})
      $display("FAIL incr_write_words: %h %h %h %h, want 1 2 3 4", sram[8'h40], sram[8'h41], sram[8'h42], sram[8'h43]);
    else passed++;
  endtask

  task automatic test_strobe_fixed;
    poke(5, 32'h0);
    do_write(4'd1, 32'h14, 8'd0, 2'b01, 4'b0010, 32'h0000AB00, 1'b0, -1, 0);
    total++;
    if (sram[5] !== 32'h0000AB00) $display("FAIL byte_strobe: mem[5]=%h, want 0000ab00", sram[5]);
    else passed++;
    do_read(4'd2, 32'h14, 8'd2, 2'b00, -1, 0);
  endtask

  task automatic test_backpressure;
    do_read(4'd7, 32'h200, 8'd3, 2'b01, 1, 5);
    do_write(4'd9, 32'h300, 8'd1, 2'b01, 4'hF, 32'h0, 1'b1, -1, 3);
  endtask

  task automatic test_arbitration;
    bit pr;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    pr = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      araddr = $urandom; awaddr = $urandom; arlen = 8'd0; awlen = 8'd0; arburst = 2'b01; awburst = 2'b01;
      arvalid = 1'b1; awvalid = 1'b1;
      @(negedge clk);
      total++;
      if ({arready, awready} !== {pr, !pr})
        $display("FAIL arbitration %0d: arready=%b awready=%b, want %b %b", t, arready, awready, pr, !pr);
      else passed++;
      arvalid = 1'b0; awvalid = 1'b0;
      if (pr) do_read(4'(t), $urandom, 8'd1, 2'b01, -1, 0);
      else    do_write(4'(t), $urandom, 8'd1, 2'b01, 4'hF, 32'h0, 1'b1, -1, 0);
      pr = !pr;
    end
  endtask

  task automatic test_early_wlast;
    do_write(4'd4, 32'h80, 8'd3, 2'b01, 4'hF, 32'h0, 1'b1, 1, 0);
    do_write(4'd5, 32'h90, 8'd1, 2'b01, 4'hF, 32'h0, 1'b1, -1, 0);
  endtask

  task automatic test_reset_mid_burst;
    bit hs;
    int c;
    @(posedge clk); #1;
    arid = 4'd9; araddr = 32'h180; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1; rready = 1'b0;
    hs = 1'b0;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    c = 0;
    @(negedge clk);
    while (!rvalid && c < 20) begin @(posedge clk); #1; c++; @(negedge clk); end
    total++;
    if (rvalid !== 1'b1) $display("FAIL pre_reset_rvalid: rvalid=%b, want 1", rvalid);
    else passed++;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    arvalid = 1'b1;
    @(negedge clk);
    total++;
    if ({rvalid, rlast, ram_en, arready} !== 4'b0001)
      $display("FAIL reset_mid_burst: rvalid=%b rlast=%b ram_en=%b arready=%b, want 0 0 0 1", rvalid, rlast, ram_en, arready);
    else passed++;
    arvalid = 1'b0;
    do_read(4'd10, 32'h180, 8'd2, 2'b01, -1, 0);
  endtask

  task automatic test_random;
    int nb;
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_read(4'($urandom), $urandom, 8'($urandom), 2'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      end else begin
        logic [7:0] len;
        len = 8'($urandom);
        nb = int'(len[3:0]) + 1;
        do_write(4'($urandom), $urandom, len, 2'($urandom), 4'h0, 32'h0, 1'b1,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1, int'($urandom_range(0, 2)));
      end
    end
  endtask

  initial begin
    reset = 1'b1; pk_en = 1'b0; pk_addr = '0; pk_data = '0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0; arcache = '0; arprot = '0;
    arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0; awcache = '0; awprot = '0;
    awvalid = 1'b0; wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
    test_reset;
    test_single_read;
    test_incr_write;
    test_strobe_fixed;
    test_backpressure;
    test_arbitration;
    test_early_wlast;
    test_reset_mid_burst;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI3 slave (responder) that serves the CPU-side sram2axi master's AR/R/AW/W/B traffic from a single-port synchronous SRAM with 1-cycle read latency. Used as a simulation/FPGA main-memory model behind the bridge. One transaction in flight at a time, either read or write. INCR and FIXED bursts of up to 16 beats.

Parameters:
ADDR_W, 16, SRAM word-address width (memory = 4*2^ADDR_W bytes)
ID_W, 4, AXI ID width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
AR: arid in ID_W, araddr in 32, arlen in 8, arsize in 3, arburst in 2, arvalid in 1, arready out 1 (arlock/arcache/arprot in, ignored)
R: rid out ID_W, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1
AW: awid in ID_W, awaddr in 32, awlen in 8, awsize in 3, awburst in 2, awvalid in 1, awready out 1 (awlock/awcache/awprot in, ignored)
W: wid in ID_W, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1
B: bid out ID_W, bresp out 2, bvalid out 1, bready in 1
SRAM: ram_en out 1, ram_wen out 4, ram_addr out ADDR_W, ram_wdata out 32, ram_rdata in 32 (valid the cycle after ram_en with ram_wen==0)

Behaviour:
- Reset: state=IDLE; arready, awready, wready, rvalid, bvalid, rlast, ram_en, ram_wen = 0; rresp = bresp = 0; rid, bid, rdata = 0. A reset mid-burst abandons the burst. No further beats or responses are issued.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP.
- IDLE: arready/awready are combinational in IDLE.
  - If only arvalid: arready=1.
  - If only awvalid: awready=1.
  - If both: grant the channel not granted last time (prio flag; reset value favours read).
  - On a read handshake: latch id, word addr = araddr[ADDR_W+1:2], beats = arlen[3:0]+1, burst; go to RD_ADDR.
  - On a write handshake: latch the same from AW; go to WR_DATA.
- RD_ADDR: ram_en=1, ram_wen=0, ram_addr=cur addr; go to RD_DATA.
- RD_DATA:
  - Register ram_rdata into rdata on entry. rvalid=1, rid=latched id, rresp=OKAY(00), rlast=(remaining==1).
  - rdata, rid, rlast are held stable while rready=0.
  - On rready: if last beat go to IDLE, else advance addr and go to RD_ADDR.
  - Latency: AR handshake at cycle T gives the first rvalid at T+2; each further beat takes 2 cycles.
- WR_DATA: wready=1.
  - On wvalid: ram_en=1, ram_wen=wstrb, ram_addr=cur addr, ram_wdata=wdata (same cycle, combinational).
  - The beat counter decides the end of the burst. If wlast disagrees with (remaining==1), set the err flag.
  - On the last beat go to WR_RESP, else advance addr.
- WR_RESP: bvalid=1, bid=latched id, bresp = err ? SLVERR(10) : OKAY(00). On bready: clear err, go to IDLE.
- Address advance: INCR (01) and WRAP (10) both add 1 to the word address, wrapping modulo 2^ADDR_W. FIXED (00) holds the address. Reserved (11) is treated as INCR.
- Address bits above ADDR_W+1 are ignored (memory aliases).
- arsize/awsize are not checked. Every beat reads or writes a full word; byte lanes come only from wstrb.
- arlen/awlen[7:4] are ignored (AXI3 max 16 beats).
- wid is ignored. W data is assumed to be in AW order.
- ram_en=0 in IDLE, WR_RESP, RD_DATA, and in WR_DATA cycles without wvalid.

Optional Feature:
AXI_SRAM_SLAVE_DELAY_EN
- Defined: an 8-bit Fibonacci LFSR (seed 8'hA5 at reset, taps 8,6,5,4) advances every cycle. On entering RD_DATA or WR_RESP, a wait counter loads lfsr[1:0] (0-3 cycles). rvalid/bvalid stay low until the counter reaches 0. Purpose: stress the master's handshakes.
- Undefined: no LFSR; timing exactly as above.

Decomposition:
- Shared package axi_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, BURST_FIXED/INCR/WRAP codes, and a state enum typedef.
- One natural sub-module: axi_sram_burst_ctr (beat counter plus address generator: load, advance, last flag), reusable by both paths.

Test Plan:
- Single read: preload mem[0x10]=32'hDEADBEEF; arid=3, araddr=0x40, arlen=0, rready=1 -> rvalid at T+2, rdata=DEADBEEF, rid=3, rlast=1, rresp=00.
- INCR write burst: awaddr=0x100, awlen=3, wdata 1..4, wstrb=F -> mem[0x40..0x43]=1,2,3,4; one bvalid, bresp=00, bid matches awid.
- Byte strobe: mem[5]=0; write 0x14, wstrb=4'b0010, wdata=32'h0000AB00 -> mem[5]=32'h0000AB00. FIXED read burst, arlen=2 -> 3 beats of the same word, rlast only on beat 3.
- Backpressure: rready held low 5 cycles on beat 2 of a 4-beat read -> rdata/rid/rlast stable, no beat lost or duplicated. bready low 3 cycles -> bvalid held.
- Simultaneous arvalid and awvalid on consecutive transactions -> read granted first after reset, then write, alternating. Early wlast on beat 2 of a 4-beat write -> 4 beats accepted, bresp=10.
- Reset asserted mid read burst -> next cycle rvalid=0, state IDLE. A new read then completes normally.
